// File: rtl/regfile_dump_checker.sv
// End-of-run register dump engine: runs the CPU for a fixed cycle budget, halts it,
// then streams every architectural register out over valid/ready with optional checking.
module regfile_dump_checker #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int IDX_W      = $clog2(NUM_REGS),
    parameter int RUN_CYCLES = 200,
    parameter int CNT_W      = $clog2(RUN_CYCLES + 1),
    parameter int CHECK_EN   = 1,
    parameter int ERR_W      = $clog2(NUM_REGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             cpu_halt,
    output logic [IDX_W-1:0] rf_rd_addr,
    input  logic [XLEN-1:0]  rf_rd_data,
    input  logic [XLEN-1:0]  exp_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [IDX_W-1:0] dump_idx,
    output logic [XLEN-1:0]  dump_data,
    output logic             dump_mismatch,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_READ = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic              mismatch_s;
    logic              handshake_s;
    logic              run_entry_s;

    assign rf_rd_addr  = idx_r;
    assign mismatch_s  = (CHECK_EN != 0) && (rf_rd_data != exp_data);
    assign handshake_s = dump_valid && dump_ready;
    assign run_entry_s = (state_r != S_RUN) && (state_s == S_RUN);

    // Next-state decode; start is only honoured from IDLE and DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_RUN;
                else       state_s = S_IDLE;
            end
            S_RUN: begin
                if (cnt_r == LAST_CNT) state_s = S_READ;
                else                   state_s = S_RUN;
            end
            S_READ: state_s = S_OUT;
            S_OUT: begin
                if (handshake_s) begin
                    if (idx_r == LAST_IDX) state_s = S_DONE;
                    else                   state_s = S_READ;
                end else begin
                    state_s = S_OUT;
                end
            end
            S_DONE: begin
                if (start) state_s = S_RUN;
                else       state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            cpu_halt      <= 1'b0;
            dump_valid    <= 1'b0;
            dump_idx      <= {IDX_W{1'b0}};
            dump_data     <= {XLEN{1'b0}};
            dump_mismatch <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= {ERR_W{1'b0}};
        end else begin
            state_r    <= state_s;
            cpu_halt   <= (state_s == S_READ) || (state_s == S_OUT) || (state_s == S_DONE);
            busy       <= (state_s == S_RUN) || (state_s == S_READ) || (state_s == S_OUT);
            done       <= (state_s == S_DONE);
            dump_valid <= (state_s == S_OUT);

            if (run_entry_s) begin
                cnt_r     <= {CNT_W{1'b0}};
                idx_r     <= {IDX_W{1'b0}};
                err_count <= {ERR_W{1'b0}};
                pass      <= 1'b0;
            end else if (state_r == S_RUN) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (state_r == S_READ) begin
                dump_idx      <= idx_r;
                dump_data     <= rf_rd_data;
                dump_mismatch <= mismatch_s;
                if (mismatch_s && (err_count != ERR_MAX)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end

            // The last handshake leaves idx at NUM_REGS-1; pass is frozen on DONE entry.
            if ((state_r == S_OUT) && handshake_s) begin
                if (idx_r == LAST_IDX) pass  <= (err_count == {ERR_W{1'b0}});
                else                   idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_checker.sv
// Directed bench for regfile_dump_checker: a default instance plus a small
// dump-only instance, both checked against a queue-based scoreboard.
module tb_regfile_dump_checker;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        mm;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dump_ready;
    logic        cpu_halt;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] exp_data;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_mismatch;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  err_count;

    logic        start2;
    logic        ready2;
    logic        cpu_halt2;
    logic [3:0]  rf_rd_addr2;
    logic [31:0] rf_rd_data2;
    logic [31:0] exp_data2;
    logic        dump_valid2;
    logic [3:0]  dump_idx2;
    logic [31:0] dump_data2;
    logic        dump_mismatch2;
    logic        busy2;
    logic        done2;
    logic        pass2;
    logic [4:0]  err_count2;

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_mem [32];

    ent_t sb[$];
    ent_t sb2[$];
    int   hs;
    int   hs2;
    int   tests;
    int   fails;

    logic        stall_q;
    logic [4:0]  held_idx;
    logic [31:0] held_data;
    logic        held_mm;

    assign rf_rd_data  = rf_mem[rf_rd_addr];
    assign exp_data    = exp_mem[rf_rd_addr];
    assign rf_rd_data2 = rf_mem[{1'b0, rf_rd_addr2}];
    assign exp_data2   = ~rf_mem[{1'b0, rf_rd_addr2}];

    regfile_dump_checker dut (
        .clk(clk), .rst(rst), .start(start), .cpu_halt(cpu_halt),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .exp_data(exp_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_mismatch(dump_mismatch), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count)
    );

    regfile_dump_checker #(.NUM_REGS(16), .RUN_CYCLES(1), .CHECK_EN(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cpu_halt(cpu_halt2),
        .rf_rd_addr(rf_rd_addr2), .rf_rd_data(rf_rd_data2), .exp_data(exp_data2),
        .dump_valid(dump_valid2), .dump_ready(ready2), .dump_idx(dump_idx2),
        .dump_data(dump_data2), .dump_mismatch(dump_mismatch2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check(tag, 64'({cpu_halt, rf_rd_addr, dump_valid, dump_idx, dump_data,
                        dump_mismatch, busy, done, pass, err_count}), 64'd0);
    endtask

    // Scoreboard monitor for the default instance: pops on handshake, checks hold under stall.
    always @(negedge clk) begin
        ent_t e;
        if (stall_q && dump_valid) begin
            check("hold_idx",  64'(dump_idx),      64'(held_idx));
            check("hold_data", 64'(dump_data),     64'(held_data));
            check("hold_mm",   64'(dump_mismatch), 64'(held_mm));
        end
        stall_q   <= rst && dump_valid && !dump_ready;
        held_idx  <= dump_idx;
        held_data <= dump_data;
        held_mm   <= dump_mismatch;
        if (rst && dump_valid && dump_ready) begin
            hs <= hs + 1;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_underflow: observed idx=%0d with no expected entry", dump_idx);
            end else begin
                e = sb.pop_front();
                check("entry_idx",  64'(dump_idx),      64'(e.idx));
                check("entry_data", 64'(dump_data),     64'(e.data));
                check("entry_mm",   64'(dump_mismatch), 64'(e.mm));
            end
        end
    end

    // Scoreboard monitor for the dump-only instance (ready tied high).
    always @(negedge clk) begin
        ent_t e;
        if (rst && dump_valid2 && ready2) begin
            hs2 <= hs2 + 1;
            if (sb2.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb2_underflow: observed idx=%0d with no expected entry", dump_idx2);
            end else begin
                e = sb2.pop_front();
                check("entry2_idx",  64'(dump_idx2),      64'(e.idx));
                check("entry2_data", 64'(dump_data2),     64'(e.data));
                check("entry2_mm",   64'(dump_mismatch2), 64'(e.mm));
            end
        end
    end

    task automatic scan(input int exp_err, input bit bp, input bit ign_pulse);
        int n;
        int m;
        int base;
        for (int i = 0; i < 32; i++) begin
            sb.push_back(ent_t'{idx: 5'(i), data: rf_mem[i], mm: (rf_mem[i] !== exp_mem[i])});
        end
        base  = hs;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done_clr", 64'(done),      64'd0);
        check("start_err_clr",  64'(err_count), 64'd0);
        check("start_halt_clr", 64'(cpu_halt),  64'd0);
        check("start_busy",     64'(busy),      64'd1);
        n = 0;
        while (!cpu_halt && n < 1000) begin
            start = (ign_pulse && n == 50) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        check("halt_edge", 64'(n), 64'd200);
        m = 0;
        while (!done && m < 5000) begin
            if (bp) dump_ready = ((m % 23) < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            m++;
        end
        dump_ready = 1'b1;
        if (!bp) check("done_latency", 64'(m), 64'd64);
        check("done",        64'(done),       64'd1);
        check("busy_done",   64'(busy),       64'd0);
        check("halt_done",   64'(cpu_halt),   64'd1);
        check("valid_done",  64'(dump_valid), 64'd0);
        check("err_count",   64'(err_count),  64'(exp_err));
        check("pass",        64'(pass),       64'(exp_err == 0));
        check("handshakes",  64'(hs - base),  64'd32);
        check("sb_drained",  64'(sb.size()),  64'd0);
    endtask

    initial begin
        int n;
        int m;
        int base2;
        tests      = 0;
        fails      = 0;
        hs         = 0;
        hs2        = 0;
        rst        = 1'b0;
        start      = 1'b0;
        dump_ready = 1'b1;
        start2     = 1'b0;
        ready2     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = $urandom;
            exp_mem[i] = rf_mem[i];
        end
        repeat (3) tick();
        check_zero("reset_state");
        rst = 1'b1;
        tick();
        check_zero("idle_no_start");

        // All registers match, free-flowing consumer.
        scan(0, 1'b0, 1'b0);
        // Random backpressure with 10-cycle stalls.
        scan(0, 1'b1, 1'b0);

        // Reset while an entry for idx 10 is being offered.
        for (int i = 0; i < 32; i++) begin
            sb.push_back(ent_t'{idx: 5'(i), data: rf_mem[i], mm: 1'b0});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(dump_valid && dump_idx == 5'd10) && n < 1000) begin
            tick();
            n++;
        end
        check("reach_idx10", 64'({dump_valid, dump_idx}), 64'({1'b1, 5'd10}));
        rst        = 1'b0;
        dump_ready = 1'b0;
        tick();
        check_zero("mid_scan_reset");
        sb.delete();
        rst        = 1'b1;
        dump_ready = 1'b1;
        repeat (2) tick();
        check_zero("idle_after_reset");
        scan(0, 1'b0, 1'b0);

        // Mismatches at idx 3 and 31, with a start pulse during RUN that must be ignored.
        exp_mem[3]  = exp_mem[3]  ^ 32'h0000_0001;
        exp_mem[31] = exp_mem[31] ^ 32'h8000_0000;
        scan(2, 1'b0, 1'b1);
        // Restart straight from DONE; the scan task checks the clears after start.
        scan(2, 1'b0, 1'b0);

        // Dump-only instance: 16 regs, one run cycle, exp_data always differs.
        for (int i = 0; i < 16; i++) begin
            sb2.push_back(ent_t'{idx: 5'(i), data: rf_mem[i], mm: 1'b0});
        end
        base2  = hs2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("p_halt_run", 64'(cpu_halt2), 64'd0);
        check("p_busy_run", 64'(busy2),     64'd1);
        tick();
        check("p_halt_next", 64'(cpu_halt2), 64'd1);
        m = 0;
        while (!done2 && m < 1000) begin
            tick();
            m++;
        end
        check("p_done_latency", 64'(m),           64'd32);
        check("p_done",         64'(done2),       64'd1);
        check("p_pass",         64'(pass2),       64'd1);
        check("p_err_count",    64'(err_count2),  64'd0);
        check("p_handshakes",   64'(hs2 - base2), 64'd16);
        check("p_sb_drained",   64'(sb2.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
